trace_capture_fifo: RTL
=======================

TRACE_CAPTURE_FIFO -- requirements
Module: trace_capture_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, ≥2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning drop counter width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port arm  input  1  meaning level-sensitive capture arm; 0 forces IDLE.
REQ-006 SHALL have port trig_pc  input  32  meaning PC value that starts capture.
REQ-007 SHALL have port wb_valid  input  1  meaning processor write-back event this cycle (register write enable).
REQ-008 SHALL have port prog_count  input  32  meaning processor debug PC.
REQ-009 SHALL have port instr_opcode  input  6  meaning processor debug opcode.
REQ-010 SHALL have port write_reg_addr  input  5  meaning processor debug write-register address.
REQ-011 SHALL have port write_reg_data  input  32  meaning processor debug write-back data.
REQ-012 SHALL have port out_ready  input  1  meaning consumer accepts head entry.
REQ-013 SHALL have port out_valid  output  1  meaning head entry valid.
REQ-014 SHALL have ports out_pc (32), out_opcode (6), out_waddr (5), out_wdata (32), all outputs, meaning head entry fields.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  meaning current entry count.
REQ-016 SHALL have port drop_count  output  CNT_W  meaning events lost to full FIFO.
REQ-017 SHALL have port state  output  2  meaning FSM state: IDLE=00, ARMED=01, CAPTURE=10.

Function
REQ-018 Event SHALL be defined as wb_valid=1 sampled at a rising edge; entry = {prog_count, instr_opcode, write_reg_addr, write_reg_data}.
REQ-019 IDLE: arm=1 SHALL move to ARMED next cycle and clear drop_count to 0; no events pushed.
REQ-020 ARMED: event with prog_count==trig_pc SHALL move to CAPTURE and that same event SHALL be pushed; other events ignored.
REQ-021 CAPTURE: every event SHALL be pushed, subject to REQ-024.
REQ-022 arm=0 in ARMED or CAPTURE SHALL move to IDLE next cycle, no push that cycle; FIFO contents retained and remain poppable.
REQ-023 Pop SHALL occur when out_valid=1 and out_ready=1; head advances, level decrements.
REQ-024 Push when level==DEPTH and no pop same cycle SHALL be dropped; drop_count increments, saturating at 2^CNT_W-1.
REQ-025 Push and pop same cycle at full SHALL both succeed; level stays DEPTH, no drop.
REQ-026 Push and pop same cycle at any other non-empty level SHALL leave level unchanged.
REQ-027 Push to empty FIFO SHALL give out_valid=1 with that entry on out_* on the next cycle (1-cycle latency); no same-cycle bypass.
REQ-028 Pop with out_valid=0 SHALL be ignored; level never underflows.
REQ-029 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-030 out_* fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 out_pc/out_opcode/out_waddr/out_wdata SHALL be 0 when out_valid=0.
REQ-032 level, drop_count, state SHALL be registered outputs.

Reset
REQ-033 rst=0 SHALL immediately, independent of clk, force state=IDLE, pointers=0, level=0, drop_count=0, out_valid=0, out_* fields=0.
REQ-034 Reset mid-capture SHALL discard all entries; the first edge after rst=1 SHALL observe arm as in IDLE.
REQ-035 FIFO storage array need not be reset; it SHALL never be visible while out_valid=0.

Verification
REQ-036 Trigger: arm=1, trig_pc=0x40; events at pc 0x38,0x3C,0x40,0x44 -> only 0x40,0x44 captured, level=2, state=10.
REQ-037 Overflow: DEPTH=16, out_ready=0, 20 events in CAPTURE -> level=16, drop_count=4, head = first event.
REQ-038 Full simultaneous: level=16, event with out_ready=1 -> level=16, drop_count unchanged, new entry at tail.
REQ-039 Wrap: push/pop 40 entries, wdata=0..39, out_ready random -> popped order 0..39, no drops, level ends 0.
REQ-040 Disarm/reset: 3 entries queued, arm=0 -> state=00, 3 entries still poppable; then rst=0 mid-pop -> out_valid=0, level=0 without a clock edge.
REQ-041 Saturation: CNT_W=4, 20 drops -> drop_count=15; re-arm from IDLE -> drop_count=0.

Source files
------------

// File: rtl/trace_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : trace_capture_fifo
//  Purpose  : Captures processor write-back events into a circular FIFO once
//             a trigger PC has been seen while armed. Counts events lost to a
//             full FIFO in a saturating drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_capture_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [31:0]              trig_pc,
  input  logic                     wb_valid,
  input  logic [31:0]              prog_count,
  input  logic [5:0]               instr_opcode,
  input  logic [4:0]               write_reg_addr,
  input  logic [31:0]              write_reg_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [5:0]               out_opcode,
  output logic [4:0]               out_waddr,
  output logic [31:0]              out_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_count,
  output logic [1:0]               state
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_lvl_w   = c_ptr_w + 1;
  localparam int c_entry_w = 32 + 6 + 5 + 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10
  } state_e;

  state_e                 state_q;
  logic [c_ptr_w-1:0]     wr_ptr_q;
  logic [c_ptr_w-1:0]     rd_ptr_q;
  logic [c_lvl_w-1:0]     level_q;
  logic [c_lvl_w-1:0]     level_d;
  logic [CNT_W-1:0]       drop_q;
  logic [CNT_W-1:0]       drop_d;
  logic [c_entry_w-1:0]   mem_q [DEPTH];

  logic                   w_trig_hit;
  logic                   w_push_req;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_drop;
  logic                   w_clear_drops;
  logic [c_entry_w-1:0]   w_entry;
  logic [c_entry_w-1:0]   w_head;

  assign w_entry    = {prog_count, instr_opcode, write_reg_addr, write_reg_data};
  assign w_trig_hit = wb_valid && (prog_count == trig_pc);

  // Arm low suppresses pushes in the same cycle that the FSM falls back to IDLE.
  assign w_push_req = arm && (((state_q == ST_ARMED) && w_trig_hit) ||
                              ((state_q == ST_CAPTURE) && wb_valid));

  assign w_full        = (level_q == c_lvl_w'(DEPTH));
  assign w_empty       = (level_q == '0);
  assign w_pop         = !w_empty && out_ready;
  // At full a concurrent pop frees the slot the push lands in.
  assign w_push_ok     = w_push_req && (!w_full || w_pop);
  assign w_drop        = w_push_req && w_full && !w_pop;
  assign w_clear_drops = (state_q == ST_IDLE) && arm;

  // Occupancy and saturating drop-counter next-state.
  always_comb begin
    level_d = level_q;
    if (w_push_ok && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (!w_push_ok && w_pop) begin
      level_d = level_q - 1'b1;
    end

    drop_d = drop_q;
    if (w_clear_drops) begin
      drop_d = '0;
    end else if (w_drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Capture control FSM: IDLE -> ARMED on arm, ARMED -> CAPTURE on trigger PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!arm)            state_q <= ST_IDLE;
          else if (w_trig_hit) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (!arm) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pointer, occupancy and drop-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage; contents are masked at the output whenever empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= w_entry;
  end

  assign w_head    = w_empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid = !w_empty;
  assign {out_pc, out_opcode, out_waddr, out_wdata} = w_head;

  assign level      = level_q;
  assign drop_count = drop_q;
  assign state      = state_q;

endmodule
`default_nettype wire
